if_fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage pipeline; feeds the decoder through an IF/ID register.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/if_pc_sel.sv | 23 ++
 rtl/if_fetch_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field layout, halt encoding and fetch-stage states.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned OPC_MSB  = 31;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t HALT_OPCODE = 5'b11111;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN,
        DONE
    } if_state_t;

    // True when the instruction word carries the halt opcode in its top field.
    function automatic logic is_halt(input logic [31:0] word);
        return opcode_t'(word[OPC_MSB -: OPCODE_W]) == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Next-PC priority mux for the fetch stage: reset, redirect, hold, sequential.
module if_pc_sel (
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        hold_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    // Redirect outranks hold so a taken branch is never lost to a stall.
    always_comb begin
        pc_next_o = pc_i + 32'd1;
        if (rst_i) begin
            pc_next_o = '0;
        end else if (redirect_i) begin
            pc_next_o = target_i;
        end else if (hold_i) begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IMEM read port,
// fills the IF/ID register and sequences halt / end-of-memory drain into Done.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter  int unsigned IMEM_DEPTH = 256,
    parameter  int unsigned PIPE_DRAIN = 4,
    localparam int unsigned AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr,
    output logic [31:0]   pc_out,
    output logic          instr_valid,
    output logic          Done
);

    localparam int unsigned CNT_W = $clog2(PIPE_DRAIN + 1);

    if_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pc_q;
    logic [31:0]        pc_next;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic               redirect;
    logic               hold;
    logic               capture;
    logic               last_word;

    // Branches are ignored once finished; the PC only advances in RUN, so
    // BOOT keeps address 0 in flight until its ROM word can be captured.
    assign redirect  = branch_taken && (state_q != DONE);
    assign hold      = stall || (state_q != RUN);
    assign capture   = (state_q == RUN) && !branch_taken && !stall;
    assign last_word = pc_q >= 32'(IMEM_DEPTH - 1);

    if_pc_sel u_pc_sel (
        .rst_i      (rst),
        .redirect_i (redirect),
        .target_i   (branch_target),
        .hold_i     (hold),
        .pc_i       (pc_q),
        .pc_next_o  (pc_next)
    );

    assign imem_addr   = pc_next[AW-1:0];
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign Done        = done_q;

    // Next-state logic for the IF/ID register, drain FSM and sticky Done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = done_q | (state_q == DONE);

        if (redirect) begin
            valid_d  = 1'b0;
            instr_d  = '0;
            pc_out_d = '0;
        end else if (stall) begin
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            valid_d  = valid_q;
        end else if (state_q == RUN) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
        end else begin
            valid_d  = 1'b0;
        end

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (capture && (is_halt(imem_rdata) || last_word)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(PIPE_DRAIN - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            cnt_q    <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_next;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

endmodule
